spi_xfer_arbiter: RTL and testbench
===================================

# spi_xfer_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master peripheral (register interface: prescale 0x00, chip-select 0x04, data 0x08, mode 0x0C) between NREQ byte-stream requesters. It drives the peripheral's ctrl_* bus. Each granted requester's transfer runs from chip-select assertion through the last byte to chip-select release. Per-byte MISO data returns on the requester's response port. It sits between on-chip masters (CPU bridge, flash/DMA readers) and the SPI peripheral.

## Interface
- NREQ, 2, number of requesters (2..8)
- CS_LENGTH, 8, peripheral chip-select width; requester i owns CS bit i; CS_LENGTH >= NREQ
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low; shared with the SPI peripheral
- req_valid  in  NREQ  requester i has a byte to send
- req_data  in  8*NREQ  TX byte, slice [8i+7:8i]
- req_last  in  NREQ  byte is the final one of the transfer
- req_ready  out  NREQ  one-cycle pulse: byte consumed
- rsp_valid  out  NREQ  one-cycle pulse: RX byte available
- rsp_data  out  8  RX byte; valid with any rsp_valid bit
- cfg_prescale  in  8*NREQ  per-requester prescale (SPI_ARB_CFG_EN only)
- cfg_mode  in  2*NREQ  per-requester {cpol,cpha} (SPI_ARB_CFG_EN only)
- busy  out  1  a transfer is in progress (state != IDLE)
- spi_wr, spi_rd  out  1  peripheral write/read strobes
- spi_addr  out  8  peripheral register address
- spi_wdat  out  32  peripheral write data
- spi_rdat  in  32  peripheral read data
- spi_done  in  1  peripheral completion pulse

## Operation
- States: IDLE, CFG_PRE, CFG_MODE, CS_ON, WAIT_BYTE, XFER_WR, XFER_RD, CS_OFF.
- IDLE: on any req_valid, the round-robin picks a grant g. Priority starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins first. Next state is CFG_PRE (macro) or CS_ON.
- CFG_PRE: write 0x00 <- cfg_prescale[g]. CFG_MODE: write 0x0C <- cfg_mode[g].
- CS_ON: write 0x04 <- CS_LENGTH ones with bit g cleared, zero-extended to 32 bits. Next state is WAIT_BYTE.
- WAIT_BYTE: when req_valid[g] is set, pulse req_ready[g], latch req_data[g] and req_last[g] into spi_wdat[7:0] and last_q, then go to XFER_WR. CS stays asserted indefinitely while waiting. Other requesters are locked out.
- XFER_WR: write 0x08 (full 8-bit shift). XFER_RD: read 0x08. On done, capture spi_rdat[7:0] into rsp_data and pulse rsp_valid[g]. Next state is CS_OFF if last_q, else WAIT_BYTE.
- CS_OFF: write 0x04 <- all CS_LENGTH ones. On done, last_grant <= g and go to IDLE.
- Bus handshake, every access: raise spi_wr or spi_rd with a stable addr/wdat and hold until spi_done is sampled 1. Drop the strobe for exactly one cycle before the next access, because the peripheral ignores requests in its done cycle. spi_wr and spi_rd are never high together.
- Arbitration happens only in IDLE. Grant is locked until CS_OFF completes.

## Timing
- Reset values: all req_ready/rsp_valid 0, spi_wr/spi_rd 0, spi_addr 0, spi_wdat 0, rsp_data 0, busy 0, state IDLE, last_grant NREQ-1.
- A req_valid sampled in IDLE at edge t enters the next state at t. The first strobe is high in cycle t+1.
- Strobe-to-strobe gap is 1 idle cycle after each spi_done. Accesses within a transfer: CS_ON and CS_OFF take prescale+1 peripheral cycles; a data write takes about 16*(prescale+1).
- req_ready[g] is high in the cycle after the edge where WAIT_BYTE samples req_valid[g]. The requester may change data in that same cycle.
- rsp_valid[g] is high for one cycle, one cycle after the read's spi_done. It has no backpressure.
- A back-to-back next transfer from a different requester starts from IDLE one cycle after CS_OFF's done.
- Reset mid-transfer returns to IDLE next edge with strobes low. The peripheral's own reset releases CS. No response is emitted for an aborted byte.

## Configuration
- SPI_ARB_CFG_EN defined: CFG_PRE and CFG_MODE run on every grant, and the cfg_* ports are used.
- SPI_ARB_CFG_EN undefined: those states and ports' logic are absent. IDLE goes straight to CS_ON, and the peripheral keeps whatever prescale/mode it already holds.

## Structure
- Package spi_arb_pkg: state enum; register address constants (REG_PRESCALE 8'h00, REG_CS 8'h04, REG_DATA 8'h08, REG_MODE 8'h0C).
- Sub-module rr_arbiter: NREQ-wide round-robin, one-hot grant plus index, advanced by a grant-accept pulse.

## Test plan
- Single 1-byte transfer from req 0, TX 0xA5 (peripheral model echoes RX 0x3C). Expect: 0x04 <- 0xFE, 0x08 <- 0xA5, read 0x08, rsp_valid[0] with 0x3C, 0x04 <- 0xFF, back to IDLE.
- Req 0 and req 1 both valid from reset. Expect req 0 served first, then req 1 with CS 0xFD. Repeat: requester 0 then 1 again, confirming round-robin alternation.
- 3-byte transfer where req_valid drops for 50 cycles after byte 1. Expect CS held at 0xFE, req 1 (valid) not granted, resume on byte 2.
- Model done delayed 7 cycles per access. Expect strobes held stable until done, a 1-cycle gap between accesses, and spi_wr/spi_rd never overlapping.
- Assert resetn low during byte 2's XFER_WR. Expect next-edge IDLE, all outputs at reset values, and no rsp_valid.
- With SPI_ARB_CFG_EN, cfg_prescale[1]=3 and cfg_mode[1]=2'b01. Expect 0x00 <- 3 and 0x0C <- 1 before the CS write. Without the macro, expect no 0x00/0x0C accesses.

Source files
------------

// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared types and SPI peripheral register map for the SPI
//               transfer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

   // Sequencer states; one peripheral access per access state.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CFG_PRE   = 3'd1,
      ST_CFG_MODE  = 3'd2,
      ST_CS_ON     = 3'd3,
      ST_WAIT_BYTE = 3'd4,
      ST_XFER_WR   = 3'd5,
      ST_XFER_RD   = 3'd6,
      ST_CS_OFF    = 3'd7
   } state_e;

   // SPI master peripheral register addresses.
   localparam logic [7:0] REG_PRESCALE = 8'h00;
   localparam logic [7:0] REG_CS       = 8'h04;
   localparam logic [7:0] REG_DATA     = 8'h08;
   localparam logic [7:0] REG_MODE     = 8'h0C;

endpackage
`default_nettype wire

// File: rtl/spi_xfer_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : NREQ-wide round-robin arbiter. Priority starts one past the
//               last accepted grant; the pointer only moves on accept_i.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [NREQ-1:0]  req_i,
   input  logic             accept_i,
   input  logic [IDX_W-1:0] accept_idx_i,
   output logic [NREQ-1:0]  grant_oh_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             any_o
);

   logic [IDX_W-1:0] last_q;

   // Remember the most recently completed grant; reset makes requester 0 first.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_q <= IDX_W'(NREQ - 1);
      end else if (accept_i) begin
         last_q <= accept_idx_i;
      end
   end

   // Scan from farthest to nearest offset so the nearest requester wins.
   always_comb begin
      int               v_pos;
      logic [IDX_W-1:0] v_cand;
      v_pos       = 0;
      v_cand      = '0;
      grant_idx_o = '0;
      any_o       = |req_i;
      for (int k = NREQ; k >= 1; k--) begin
         v_pos  = (int'(last_q) + k) % NREQ;
         v_cand = IDX_W'(v_pos);
         if (req_i[v_cand]) begin
            grant_idx_o = v_cand;
         end
      end
      grant_oh_o = any_o ? (NREQ'(1) << grant_idx_o) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_arbiter
// Description : Round-robin arbiter and transaction sequencer sharing one SPI
//               master peripheral between NREQ byte-stream requesters.
//               Optional macro SPI_ARB_CFG_EN: reprogram prescale and mode
//               from the cfg_* ports at the start of every grant.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int CS_LENGTH = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [7:0]        rsp_data,
   input  logic [8*NREQ-1:0] cfg_prescale,
   input  logic [2*NREQ-1:0] cfg_mode,
   output logic              busy,
   output logic              spi_wr,
   output logic              spi_rd,
   output logic [7:0]        spi_addr,
   output logic [31:0]       spi_wdat,
   input  logic [31:0]       spi_rdat,
   input  logic              spi_done
);

   localparam int          IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [31:0] c_cs_all = 32'({CS_LENGTH{1'b1}});

   // Chip-select word with only the granted requester's line driven low.
   function automatic logic [31:0] cs_word(input logic [IDX_W-1:0] idx);
      logic [CS_LENGTH-1:0] v;
      v      = {CS_LENGTH{1'b1}};
      v[idx] = 1'b0;
      return 32'(v);
   endfunction

   state_e           state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic             last_q, last_d;
   logic             spi_wr_q, spi_wr_d;
   logic             spi_rd_q, spi_rd_d;
   logic [7:0]       spi_addr_q, spi_addr_d;
   logic [31:0]      spi_wdat_q, spi_wdat_d;
   logic [7:0]       rsp_data_q, rsp_data_d;
   logic [NREQ-1:0]  req_ready_q, req_ready_d;
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;

   logic             w_accept;
   logic [NREQ-1:0]  w_arb_oh;
   logic [IDX_W-1:0] w_arb_idx;
   logic             w_arb_any;
   logic [7:0]       w_req_byte [NREQ];
   logic             w_unused;

   for (genvar i = 0; i < NREQ; i++) begin : g_req_split
      assign w_req_byte[i] = req_data[8*i +: 8];
   end

`ifdef SPI_ARB_CFG_EN
   logic [7:0] w_cfg_pre  [NREQ];
   logic [1:0] w_cfg_mode [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_cfg_split
      assign w_cfg_pre[i]  = cfg_prescale[8*i +: 8];
      assign w_cfg_mode[i] = cfg_mode[2*i +: 2];
   end

   assign w_unused = ^{spi_rdat[31:8], w_arb_oh};
`else
   assign w_unused = ^{spi_rdat[31:8], w_arb_oh, cfg_prescale, cfg_mode};
`endif

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .clk          (clk),
      .resetn       (resetn),
      .req_i        (req_valid),
      .accept_i     (w_accept),
      .accept_idx_i (grant_q),
      .grant_oh_o   (w_arb_oh),
      .grant_idx_o  (w_arb_idx),
      .any_o        (w_arb_any)
   );

   // State and registered bus/response outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         last_q      <= 1'b0;
         spi_wr_q    <= 1'b0;
         spi_rd_q    <= 1'b0;
         spi_addr_q  <= '0;
         spi_wdat_q  <= '0;
         rsp_data_q  <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         spi_wr_q    <= spi_wr_d;
         spi_rd_q    <= spi_rd_d;
         spi_addr_q  <= spi_addr_d;
         spi_wdat_q  <= spi_wdat_d;
         rsp_data_q  <= rsp_data_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Next state and bus access: a strobe is raised when its state is entered
   // (or one cycle after the previous done), held until done, then dropped.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      spi_wr_d    = spi_wr_q;
      spi_rd_d    = spi_rd_q;
      spi_addr_d  = spi_addr_q;
      spi_wdat_d  = spi_wdat_q;
      rsp_data_d  = rsp_data_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      w_accept    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_arb_any) begin
               grant_d  = w_arb_idx;
               spi_wr_d = 1'b1;
`ifdef SPI_ARB_CFG_EN
               state_d    = ST_CFG_PRE;
               spi_addr_d = REG_PRESCALE;
               spi_wdat_d = {24'h0, w_cfg_pre[w_arb_idx]};
`else
               state_d    = ST_CS_ON;
               spi_addr_d = REG_CS;
               spi_wdat_d = cs_word(w_arb_idx);
`endif
            end
         end
`ifdef SPI_ARB_CFG_EN
         ST_CFG_PRE: begin
            if (spi_wr_q && spi_done) begin
               spi_wr_d = 1'b0;
               state_d  = ST_CFG_MODE;
            end
         end
         ST_CFG_MODE: begin
            if (!spi_wr_q) begin
               spi_wr_d   = 1'b1;
               spi_addr_d = REG_MODE;
               spi_wdat_d = {30'h0, w_cfg_mode[grant_q]};
            end else if (spi_done) begin
               spi_wr_d = 1'b0;
               state_d  = ST_CS_ON;
            end
         end
`endif
         ST_CS_ON: begin
            if (!spi_wr_q) begin
               spi_wr_d   = 1'b1;
               spi_addr_d = REG_CS;
               spi_wdat_d = cs_word(grant_q);
            end else if (spi_done) begin
               spi_wr_d = 1'b0;
               state_d  = ST_WAIT_BYTE;
            end
         end
         ST_WAIT_BYTE: begin
            // CS stays asserted here for as long as the owner withholds data.
            if (req_valid[grant_q]) begin
               req_ready_d[grant_q] = 1'b1;
               last_d               = req_last[grant_q];
               spi_wr_d             = 1'b1;
               spi_addr_d           = REG_DATA;
               spi_wdat_d           = {24'h0, w_req_byte[grant_q]};
               state_d              = ST_XFER_WR;
            end
         end
         ST_XFER_WR: begin
            if (!spi_wr_q) begin
               spi_wr_d   = 1'b1;
               spi_addr_d = REG_DATA;
            end else if (spi_done) begin
               spi_wr_d = 1'b0;
               state_d  = ST_XFER_RD;
            end
         end
         ST_XFER_RD: begin
            if (!spi_rd_q) begin
               spi_rd_d   = 1'b1;
               spi_addr_d = REG_DATA;
            end else if (spi_done) begin
               spi_rd_d             = 1'b0;
               rsp_data_d           = spi_rdat[7:0];
               rsp_valid_d[grant_q] = 1'b1;
               state_d              = last_q ? ST_CS_OFF : ST_WAIT_BYTE;
            end
         end
         ST_CS_OFF: begin
            if (!spi_wr_q) begin
               spi_wr_d   = 1'b1;
               spi_addr_d = REG_CS;
               spi_wdat_d = c_cs_all;
            end else if (spi_done) begin
               spi_wr_d = 1'b0;
               w_accept = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign spi_wr    = spi_wr_q;
   assign spi_rd    = spi_rd_q;
   assign spi_addr  = spi_addr_q;
   assign spi_wdat  = spi_wdat_q;
   assign rsp_data  = rsp_data_q;
   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_arbiter
// Description : Self-checking bench for spi_xfer_arbiter with an SPI
//               peripheral model, requester drivers and an expected
//               bus-access list built from transfer-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_arbiter;

   localparam int NREQ = 2;

   typedef struct packed {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdat;
   } acc_t;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [8*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   req_last = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_data;
   logic [8*NREQ-1:0] cfg_prescale = '0;
   logic [2*NREQ-1:0] cfg_mode = '0;
   logic              busy;
   logic              spi_wr;
   logic              spi_rd;
   logic [7:0]        spi_addr;
   logic [31:0]       spi_wdat;
   logic [31:0]       spi_rdat = '0;
   logic              spi_done = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   acc_t       log_q[$];
   acc_t       exp_q[$];
   int         gap_q[$];
   logic [8:0] rsp_exp_q[$];
   logic [8:0] txq0[$];
   logic [8:0] txq1[$];

   int         lat_fix = -1;
   logic       rx_force = 1'b0;
   logic       m_active = 1'b0;
   int         m_cnt = 0;
   acc_t       m_cur = '0;
   int         cyc = 0;
   int         last_done_cyc = 0;
   logic [7:0] cs_reg = 8'hFF;
   logic [7:0] m_rx = '0;
   int         rsp_cnt = 0;
   int         rdy_cnt1 = 0;

   always #5 clk = ~clk;

   spi_xfer_arbiter #(.NREQ(NREQ), .CS_LENGTH(8)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .cfg_prescale (cfg_prescale),
      .cfg_mode     (cfg_mode),
      .busy         (busy),
      .spi_wr       (spi_wr),
      .spi_rd       (spi_rd),
      .spi_addr     (spi_addr),
      .spi_wdat     (spi_wdat),
      .spi_rdat     (spi_rdat),
      .spi_done     (spi_done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic acc_t mk(input logic wr, input logic [7:0] addr, input logic [31:0] wdat);
      acc_t a;
      a.wr   = wr;
      a.addr = addr;
      a.wdat = wdat;
      return a;
   endfunction

   function automatic int req_of(input logic [7:0] cs);
      for (int i = 0; i < NREQ; i++) begin
         if (!cs[i]) return i;
      end
      return 0;
   endfunction

   // Peripheral model plus response monitor, evaluated on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (|rsp_valid) begin
         rsp_cnt++;
         if (rsp_exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'h0);
         end else begin
            logic [8:0] e;
            e = rsp_exp_q.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(2'b01 << e[8]));
            check("rsp_data", 64'(rsp_data), 64'(e[7:0]));
         end
      end
      if (spi_wr && spi_rd) check("wr_rd_overlap", 64'({spi_wr, spi_rd}), 64'h2);
      if (!resetn) begin
         m_active = 1'b0;
         spi_done = 1'b0;
         cs_reg   = 8'hFF;
      end else if (spi_done) begin
         spi_done = 1'b0;
         check("gap_after_done", 64'({spi_wr, spi_rd}), 64'h0);
      end else if (spi_wr || spi_rd) begin
         if (!m_active) begin
            m_active = 1'b1;
            m_cur    = mk(spi_wr, spi_addr, spi_rd ? 32'h0 : spi_wdat);
            log_q.push_back(m_cur);
            gap_q.push_back(cyc - last_done_cyc - 1);
            m_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            if (spi_rd) begin
               m_rx     = rx_force ? 8'h3C : 8'($urandom);
               spi_rdat = {24'($urandom), m_rx};
               rsp_exp_q.push_back({1'(req_of(cs_reg)), m_rx});
            end
         end else begin
            check("strobe_stable", 64'(mk(spi_wr, spi_addr, spi_rd ? 32'h0 : spi_wdat)), 64'(m_cur));
         end
         if (m_cnt == 0) begin
            spi_done      = 1'b1;
            m_active      = 1'b0;
            last_done_cyc = cyc;
            if (m_cur.wr && m_cur.addr == 8'h04) cs_reg = m_cur.wdat[7:0];
         end else begin
            m_cnt--;
         end
      end else if (m_active) begin
         check("strobe_held", 64'(spi_wr | spi_rd), 64'h1);
         m_active = 1'b0;
      end
   end

   // Requester drivers: each queue entry is {last, data}.
   always @(negedge clk) begin
      if (req_ready[0]) begin
         check("ready0_has_byte", 64'(txq0.size() > 0), 64'h1);
         if (txq0.size() > 0) void'(txq0.pop_front());
      end
      if (req_ready[1]) begin
         rdy_cnt1++;
         check("ready1_has_byte", 64'(txq1.size() > 0), 64'h1);
         if (txq1.size() > 0) void'(txq1.pop_front());
      end
      req_valid[0] = (txq0.size() != 0);
      {req_last[0], req_data[7:0]} = (txq0.size() != 0) ? txq0[0] : 9'h0;
      req_valid[1] = (txq1.size() != 0);
      {req_last[1], req_data[15:8]} = (txq1.size() != 0) ? txq1[0] : 9'h0;
   end

   task automatic tx_push(input int g, input logic [7:0] b, input logic last);
      if (g == 0) txq0.push_back({last, b});
      else        txq1.push_back({last, b});
   endtask

   task automatic exp_open(input int g);
`ifdef SPI_ARB_CFG_EN
      exp_q.push_back(mk(1'b1, 8'h00, 32'(cfg_prescale[8*g +: 8])));
      exp_q.push_back(mk(1'b1, 8'h0C, 32'(cfg_mode[2*g +: 2])));
`endif
      exp_q.push_back(mk(1'b1, 8'h04, 32'(8'hFF - (8'h01 << g))));
   endtask

   task automatic exp_byte(input logic [7:0] b);
      exp_q.push_back(mk(1'b1, 8'h08, 32'(b)));
      exp_q.push_back(mk(1'b0, 8'h08, 32'h0));
   endtask

   task automatic exp_close();
      exp_q.push_back(mk(1'b1, 8'h04, 32'h0000_00FF));
   endtask

   task automatic send_byte(input int g, input logic [7:0] b, input logic last);
      tx_push(g, b, last);
      exp_byte(b);
   endtask

   task automatic do_rand(input int g, input int n);
      exp_open(g);
      for (int i = 0; i < n; i++) send_byte(g, 8'($urandom), (i == n - 1));
      exp_close();
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (!(txq0.size() == 0 && txq1.size() == 0 && !busy && !spi_wr && !spi_rd) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", 64'(k < budget), 64'h1);
   endtask

   task automatic compare_log(input logic chk_gap);
      int n;
      check("log_len", 64'(log_q.size()), 64'(exp_q.size()));
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("access%0d", i), 64'(log_q[i]), 64'(exp_q[i]));
         if (chk_gap && i > 0) check($sformatf("gap%0d", i), 64'(gap_q[i]), 64'h1);
      end
      check("rsp_missing", 64'(rsp_exp_q.size()), 64'h0);
      log_q.delete();
      exp_q.delete();
      gap_q.delete();
      rsp_exp_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   function automatic int n_data_wr();
      int n;
      n = 0;
      foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr == 8'h08) n++;
      return n;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  64'(busy), 64'h0);
      check({tag, "_strb"},  64'({spi_wr, spi_rd}), 64'h0);
      check({tag, "_addr"},  64'(spi_addr), 64'h0);
      check({tag, "_wdat"},  64'(spi_wdat), 64'h0);
      check({tag, "_rdata"}, 64'(rsp_data), 64'h0);
      check({tag, "_hs"},    64'({req_ready, rsp_valid}), 64'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int r0;
      logic [7:0] b1;
      cfg_prescale = {8'd3, 8'($urandom)};
      cfg_mode     = {2'b01, 2'($urandom)};
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      resetn = 1'b1;

      // Single byte from requester 0; first strobe in the cycle after arbitration.
      @(posedge clk); #1;
      rx_force = 1'b1;
      exp_open(0);
      send_byte(0, 8'hA5, 1'b1);
      exp_close();
      @(negedge clk);
      @(negedge clk);
      check("first_strobe", 64'(mk(spi_wr, spi_addr, spi_wdat)), 64'(exp_q[0]));
      check("busy_active", 64'(busy), 64'h1);
      wait_idle(1000);
      compare_log(1'b0);
      rx_force = 1'b0;

      // Both requesters valid from reset, two rounds: 0 then 1 each time.
      do_reset();
      for (int round = 0; round < 2; round++) begin
         @(posedge clk); #1;
         do_rand(0, int'($urandom_range(1, 3)));
         do_rand(1, int'($urandom_range(1, 3)));
         wait_idle(3000);
         compare_log(1'b0);
      end

      // Requester 0 stalls mid-transfer; requester 1 must stay locked out.
      @(posedge clk); #1;
      exp_open(0);
      send_byte(0, 8'($urandom), 1'b0);
      b1 = 8'($urandom);
      tx_push(1, b1, 1'b1);
      k = 0;
      while (txq0.size() != 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("stall_start_timeout", 64'(k < 500), 64'h1);
      r0 = rdy_cnt1;
      repeat (50) @(negedge clk);
      check("stall_cs", 64'(cs_reg), 64'hFE);
      check("stall_busy", 64'(busy), 64'h1);
      check("stall_lockout", 64'(rdy_cnt1), 64'(r0));
      check("stall_bus_quiet", 64'({spi_wr, spi_rd}), 64'h0);
      @(posedge clk); #1;
      send_byte(0, 8'($urandom), 1'b0);
      send_byte(0, 8'($urandom), 1'b1);
      exp_close();
      exp_open(1);
      exp_byte(b1);
      exp_close();
      wait_idle(3000);
      compare_log(1'b0);

      // Slow peripheral: strobes held, exactly one idle cycle between accesses.
      lat_fix = 7;
      @(posedge clk); #1;
      do_rand(0, 2);
      wait_idle(3000);
      compare_log(1'b1);

      // Reset during the second byte's data write.
      lat_fix = 10;
      @(posedge clk); #1;
      do_rand(0, 3);
      k = 0;
      while (!(n_data_wr() == 2 && m_active && spi_wr) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("abort_point_timeout", 64'(k < 1000), 64'h1);
      r0 = rsp_cnt;
      resetn = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("abort");
      txq0.delete();
      txq1.delete();
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_rsp", 64'(rsp_cnt), 64'(r0));
      log_q.delete();
      exp_q.delete();
      gap_q.delete();
      rsp_exp_q.delete();
      resetn = 1'b1;
      lat_fix = -1;

      // After reset the round-robin pointer restarts at requester 0.
      @(posedge clk); #1;
      do_rand(0, 1);
      do_rand(1, 2);
      wait_idle(3000);
      compare_log(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
